cv32e40s_mpu_ordq: RTL and testbench

Non-blocking, in-order response queue for the MPU. It replaces drain-and-block error handling: an access that fails its PMA/PMP check is consumed immediately, and its fault response is returned to the core in program order relative to the surrounding bus transactions. Up to DEPTH transactions (bus or faulted) may be outstanding at once. It sits between the core-side LSU/IF request path and the OBI bus interface; the PMA/PMP checkers stay outside and feed `chk_err_i`.

---
 rtl/cv32e40s_mpu_ordq_pkg.sv | 37 +++
 rtl/cv32e40s_mpu_ordq_pick.sv | 31 +++
 rtl/cv32e40s_mpu_ordq.sv | 125 ++++++++++++
 tb/tb_cv32e40s_mpu_ordq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_mpu_ordq_pkg.sv
// cv32e40s_mpu_ordq_pkg: shared types for the MPU in-order response queue.
package cv32e40s_mpu_ordq_pkg;

    localparam int MPU_ORDQ_MAX_DEPTH = 8;

    typedef enum logic [1:0] {
        MPU_OK       = 2'd0,
        MPU_RE_FAULT = 2'd1,
        MPU_WR_FAULT = 2'd2
    } mpu_status_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_inst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_inst_resp_t;

    typedef struct packed {
        obi_inst_resp_t bus_resp;
        mpu_status_e    mpu_status;
        logic           wpt_match;
    } inst_resp_t;

    typedef struct packed {
        logic           is_err;
        logic           is_wr;
        logic           rsp_vld;
        obi_inst_resp_t rsp;
    } ordq_entry_t;

endpackage

// File: rtl/cv32e40s_mpu_ordq_pick.sv
// cv32e40s_mpu_ordq_pick: finds the oldest matching queue slot, scanning
// in age order starting at rd_ptr.
module cv32e40s_mpu_ordq_pick
    import cv32e40s_mpu_ordq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic [DEPTH-1:0] match,
    input  logic [PW-1:0]    rd_ptr,
    output logic             found,
    output logic [PW-1:0]    idx
);

    logic [PW-1:0] j;

    // Descending scan so the slot closest to rd_ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            j = PW'((int'(rd_ptr) + k) % DEPTH);
            if (match[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/cv32e40s_mpu_ordq.sv
// cv32e40s_mpu_ordq: non-blocking in-order response queue returning PMA/PMP
// faults and bus responses to the core in program order.
module cv32e40s_mpu_ordq
    import cv32e40s_mpu_ordq_pkg::*;
#(
    parameter int  IF_STAGE       = 1,
    parameter type CORE_REQ_TYPE  = obi_inst_req_t,
    parameter type CORE_RESP_TYPE = inst_resp_t,
    parameter type BUS_RESP_TYPE  = obi_inst_resp_t,
    parameter int  DEPTH          = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       core_trans_valid_i,
    output logic                       core_trans_ready_o,
    input  CORE_REQ_TYPE               core_trans_i,
    input  logic                       chk_err_i,
    output logic                       bus_trans_valid_o,
    input  logic                       bus_trans_ready_i,
    output CORE_REQ_TYPE               bus_trans_o,
    input  logic                       bus_resp_valid_i,
    input  BUS_RESP_TYPE               bus_resp_i,
    output logic                       core_resp_valid_o,
    output CORE_RESP_TYPE              core_resp_o,
    output logic                       core_mpu_err_o,
    output logic [$clog2(DEPTH+1)-1:0] txn_cnt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > MPU_ORDQ_MAX_DEPTH) begin : g_bad_depth
        $error("cv32e40s_mpu_ordq: DEPTH out of range");
    end

    typedef struct packed {
        logic         is_err;
        logic         is_wr;
        logic         rsp_vld;
        BUS_RESP_TYPE rsp;
    } entry_t;

    entry_t           q [DEPTH];
    entry_t           head;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] tgt;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    tgt_idx;
    logic [CW-1:0]    count;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             store;
    logic             tgt_found;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_tgt
        assign tgt[i] = vld[i] && !q[i].is_err && !q[i].rsp_vld;
    end

    cv32e40s_mpu_ordq_pick #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_pick (
        .match  (tgt),
        .rd_ptr (rd_ptr),
        .found  (tgt_found),
        .idx    (tgt_idx)
    );

    assign full               = count == CW'(DEPTH);
    assign head               = q[rd_ptr];
    assign bus_trans_o        = core_trans_i;
    assign bus_trans_valid_o  = core_trans_valid_i && !chk_err_i && !full;
    assign core_trans_ready_o = !full && (chk_err_i || bus_trans_ready_i);
    assign core_mpu_err_o     = core_trans_valid_i && chk_err_i;
    assign push               = core_trans_valid_i && core_trans_ready_o;
    assign bypass             = vld[rd_ptr] && !head.is_err && !head.rsp_vld && bus_resp_valid_i
                                && tgt_found && (tgt_idx == rd_ptr);
    assign pop                = vld[rd_ptr] && (head.is_err || head.rsp_vld || bypass);
    assign store              = bus_resp_valid_i && tgt_found && !bypass;
    assign core_resp_valid_o  = pop;
    assign txn_cnt_o          = count;

    always_comb begin
        core_resp_o            = '0;
        core_resp_o.mpu_status = (pop && head.is_err) ? (head.is_wr ? MPU_WR_FAULT : MPU_RE_FAULT) : MPU_OK;
        core_resp_o.bus_resp   = (pop && !head.is_err) ? (head.rsp_vld ? head.rsp : bus_resp_i) : BUS_RESP_TYPE'('0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            if (store) begin
                q[tgt_idx].rsp_vld <= 1'b1;
                q[tgt_idx].rsp     <= bus_resp_i;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= nxt(rd_ptr);
            end
            if (push) begin
                vld[wr_ptr]       <= 1'b1;
                q[wr_ptr].is_err  <= chk_err_i;
                q[wr_ptr].is_wr   <= core_trans_i.we && (IF_STAGE == 0);
                q[wr_ptr].rsp_vld <= 1'b0;
                wr_ptr            <= nxt(wr_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_resp_has_target: assert property (@(posedge clk) disable iff (!rst_n) bus_resp_valid_i |-> tgt_found);

endmodule

// File: tb/tb_cv32e40s_mpu_ordq.sv
// tb_cv32e40s_mpu_ordq: directed scenarios plus randomized traffic checked
// against a queue-based model, on a DEPTH=2 data-side and DEPTH=4 fetch-side instance.
module tb_cv32e40s_mpu_ordq;
    import cv32e40s_mpu_ordq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           tv [2];
    logic           tc [2];
    logic           tg [2];
    logic           rv [2];
    obi_inst_req_t  req [2];
    obi_inst_resp_t rsp [2];
    logic           rdy [2];
    logic           bv [2];
    logic           crv [2];
    logic           merr [2];
    obi_inst_req_t  breq [2];
    inst_resp_t     cr [2];
    logic [1:0]     cnt_a;
    logic [2:0]     cnt_b;
    logic [3:0]     cnt [2];

    int tests_run = 0;
    int tests_failed = 0;

    assign cnt[0] = {2'b00, cnt_a};
    assign cnt[1] = {1'b0, cnt_b};

    cv32e40s_mpu_ordq #(.IF_STAGE(0), .DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .core_trans_valid_i(tv[0]), .core_trans_ready_o(rdy[0]), .core_trans_i(req[0]),
        .chk_err_i(tc[0]), .bus_trans_valid_o(bv[0]), .bus_trans_ready_i(tg[0]),
        .bus_trans_o(breq[0]), .bus_resp_valid_i(rv[0]), .bus_resp_i(rsp[0]),
        .core_resp_valid_o(crv[0]), .core_resp_o(cr[0]), .core_mpu_err_o(merr[0]),
        .txn_cnt_o(cnt_a)
    );

    cv32e40s_mpu_ordq #(.IF_STAGE(1), .DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .core_trans_valid_i(tv[1]), .core_trans_ready_o(rdy[1]), .core_trans_i(req[1]),
        .chk_err_i(tc[1]), .bus_trans_valid_o(bv[1]), .bus_trans_ready_i(tg[1]),
        .bus_trans_o(breq[1]), .bus_resp_valid_i(rv[1]), .bus_resp_i(rsp[1]),
        .core_resp_valid_o(crv[1]), .core_resp_o(cr[1]), .core_mpu_err_o(merr[1]),
        .txn_cnt_o(cnt_b)
    );

    typedef struct {
        bit             err;
        bit             wr;
        bit             has;
        obi_inst_resp_t rsp;
    } m_t;

    // Snapshot: {ready, bus_valid, resp_valid, mpu_status, txn_cnt}.
    function automatic logic [8:0] obs(input int s);
        return {rdy[s], bv[s], crv[s], cr[s].mpu_status, cnt[s]};
    endfunction

    task automatic drive(input int s, input logic v, input logic c, input logic w, input logic g,
                         input logic r, input logic [31:0] d, input logic e);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tv[i] = 1'b0; tc[i] = 1'b0; tg[i] = 1'b0; rv[i] = 1'b0;
            req[i] = '0; rsp[i] = '0;
        end
        tv[s] = v; tc[s] = c; tg[s] = g; rv[s] = r;
        req[s].we = w; req[s].addr = $urandom; req[s].wdata = $urandom; req[s].be = 4'(w ? 4'hf : 4'h0);
        rsp[s].rdata = d; rsp[s].err = e;
        #1;
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b100, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL reset_u2: got %b want %b", obs(0), {3'b100, MPU_OK, 4'd0}); end
        tests_run++; if (obs(1) !== {3'b000, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL reset_u4: got %b want %b", obs(1), {3'b000, MPU_OK, 4'd0}); end
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b010, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL reset_nogrant: got %b want %b", obs(0), {3'b010, MPU_OK, 4'd0}); end
    endtask

    task automatic test_fault_read;
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b100, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL fault_c0: got %b want %b", obs(0), {3'b100, MPU_OK, 4'd0}); end
        tests_run++; if (merr[0] !== 1'b1) begin tests_failed++; $display("FAIL fault_mpu_err: got %b want 1", merr[0]); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b001, MPU_RE_FAULT, 4'd1}) begin tests_failed++; $display("FAIL fault_c1: got %b want %b", obs(0), {3'b001, MPU_RE_FAULT, 4'd1}); end
        tests_run++; if (cr[0].bus_resp !== 33'd0) begin tests_failed++; $display("FAIL fault_busresp: got %h want 0", cr[0].bus_resp); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b000, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL fault_c2: got %b want %b", obs(0), {3'b000, MPU_OK, 4'd0}); end
    endtask

    task automatic test_ordering;
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b110, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL order_c0: got %b want %b", obs(0), {3'b110, MPU_OK, 4'd0}); end
        drive(0, 1, 1, 1, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b100, MPU_OK, 4'd1}) begin tests_failed++; $display("FAIL order_c1: got %b want %b", obs(0), {3'b100, MPU_OK, 4'd1}); end
        drive(0, 0, 0, 0, 0, 1, 32'h1111, 0);
        tests_run++; if (obs(0) !== {3'b001, MPU_OK, 4'd2}) begin tests_failed++; $display("FAIL order_c2: got %b want %b", obs(0), {3'b001, MPU_OK, 4'd2}); end
        tests_run++; if (cr[0].bus_resp.rdata !== 32'h1111) begin tests_failed++; $display("FAIL order_rdata: got %h want 1111", cr[0].bus_resp.rdata); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b001, MPU_WR_FAULT, 4'd1}) begin tests_failed++; $display("FAIL order_c3: got %b want %b", obs(0), {3'b001, MPU_WR_FAULT, 4'd1}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b000, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL order_c4: got %b want %b", obs(0), {3'b000, MPU_OK, 4'd0}); end
    endtask

    task automatic test_full;
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b110, MPU_OK, 4'd1}) begin tests_failed++; $display("FAIL full_c1: got %b want %b", obs(0), {3'b110, MPU_OK, 4'd1}); end
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b000, MPU_OK, 4'd2}) begin tests_failed++; $display("FAIL full_c2: got %b want %b", obs(0), {3'b000, MPU_OK, 4'd2}); end
        drive(0, 1, 0, 0, 1, 1, 32'hA, 0);
        tests_run++; if (obs(0) !== {3'b001, MPU_OK, 4'd2}) begin tests_failed++; $display("FAIL full_pop_no_push: got %b want %b", obs(0), {3'b001, MPU_OK, 4'd2}); end
        tests_run++; if (cr[0].bus_resp.rdata !== 32'hA) begin tests_failed++; $display("FAIL full_rdata_a: got %h want a", cr[0].bus_resp.rdata); end
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b110, MPU_OK, 4'd1}) begin tests_failed++; $display("FAIL full_c4: got %b want %b", obs(0), {3'b110, MPU_OK, 4'd1}); end
        drive(0, 0, 0, 0, 0, 1, 32'hB, 0);
        tests_run++; if ({obs(0), cr[0].bus_resp.rdata} !== {3'b001, MPU_OK, 4'd2, 32'hB}) begin tests_failed++; $display("FAIL full_c5: got %h want %h", {obs(0), cr[0].bus_resp.rdata}, {3'b001, MPU_OK, 4'd2, 32'hB}); end
        drive(0, 0, 0, 0, 0, 1, 32'hC, 0);
        tests_run++; if ({obs(0), cr[0].bus_resp.rdata} !== {3'b001, MPU_OK, 4'd1, 32'hC}) begin tests_failed++; $display("FAIL full_c6: got %h want %h", {obs(0), cr[0].bus_resp.rdata}, {3'b001, MPU_OK, 4'd1, 32'hC}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b000, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL full_c7: got %b want %b", obs(0), {3'b000, MPU_OK, 4'd0}); end
    endtask

    task automatic test_bypass;
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b110, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL bypass_c0: got %b want %b", obs(0), {3'b110, MPU_OK, 4'd0}); end
        drive(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1);
        tests_run++; if (obs(0) !== {3'b001, MPU_OK, 4'd1}) begin tests_failed++; $display("FAIL bypass_c1: got %b want %b", obs(0), {3'b001, MPU_OK, 4'd1}); end
        tests_run++; if (cr[0].bus_resp !== {32'hDEADBEEF, 1'b1}) begin tests_failed++; $display("FAIL bypass_resp: got %h want %h", cr[0].bus_resp, {32'hDEADBEEF, 1'b1}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b000, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL bypass_c2: got %b want %b", obs(0), {3'b000, MPU_OK, 4'd0}); end
    endtask

    task automatic test_stored;
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        tests_run++; if (obs(1) !== {3'b110, MPU_OK, 4'd3}) begin tests_failed++; $display("FAIL stored_c3: got %b want %b", obs(1), {3'b110, MPU_OK, 4'd3}); end
        drive(1, 1, 1, 0, 0, 1, 32'h5, 0);
        tests_run++; if ({obs(1), cr[1].bus_resp.rdata} !== {3'b001, MPU_OK, 4'd4, 32'h5}) begin tests_failed++; $display("FAIL stored_full_bypass: got %h want %h", {obs(1), cr[1].bus_resp.rdata}, {3'b001, MPU_OK, 4'd4, 32'h5}); end
        drive(1, 0, 0, 0, 0, 1, 32'h2222, 0);
        tests_run++; if (obs(1) !== {3'b001, MPU_RE_FAULT, 4'd3}) begin tests_failed++; $display("FAIL stored_e0: got %b want %b", obs(1), {3'b001, MPU_RE_FAULT, 4'd3}); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(1) !== {3'b001, MPU_RE_FAULT, 4'd2}) begin tests_failed++; $display("FAIL stored_e1_ifstage: got %b want %b", obs(1), {3'b001, MPU_RE_FAULT, 4'd2}); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if ({obs(1), cr[1].bus_resp.rdata} !== {3'b001, MPU_OK, 4'd1, 32'h2222}) begin tests_failed++; $display("FAIL stored_b2: got %h want %h", {obs(1), cr[1].bus_resp.rdata}, {3'b001, MPU_OK, 4'd1, 32'h2222}); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(1) !== {3'b000, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL stored_end: got %b want %b", obs(1), {3'b000, MPU_OK, 4'd0}); end
    endtask

    task automatic test_random(input int s, input int n);
        m_t             mq[$];
        int             d;
        bit             ifs;
        logic           v, c, w, g, r, e, full, ery, ebv, erv;
        logic [31:0]    dat;
        logic [3:0]     ecnt;
        int             pend;
        mpu_status_e    est;
        obi_inst_resp_t ersp;
        m_t             ne;
        d   = (s != 0) ? 4 : 2;
        ifs = (s != 0);
        for (int cyc = 0; cyc < n + 12; cyc++) begin
            v   = (cyc < n) ? 1'($urandom % 2) : 1'b0;
            c   = 1'($urandom % 3 == 0);
            w   = 1'($urandom % 2);
            g   = 1'($urandom % 2);
            e   = 1'($urandom % 2);
            dat = $urandom;
            pend = 0;
            foreach (mq[i]) if (!mq[i].err && !mq[i].has) pend++;
            r    = (pend > 0) && ((cyc >= n) || ($urandom % 2 == 0));
            ecnt = 4'(mq.size());
            full = (mq.size() == d);
            ery  = !full && (c || g);
            ebv  = v && !c && !full;
            if (r) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].err && !mq[i].has) begin
                        mq[i].has = 1'b1;
                        mq[i].rsp = '{rdata: dat, err: e};
                        break;
                    end
                end
            end
            erv  = 1'b0;
            est  = MPU_OK;
            ersp = '0;
            if (mq.size() > 0) begin
                if (mq[0].err) begin
                    erv = 1'b1;
                    est = mq[0].wr ? MPU_WR_FAULT : MPU_RE_FAULT;
                end else if (mq[0].has) begin
                    erv  = 1'b1;
                    ersp = mq[0].rsp;
                end
            end
            drive(s, v, c, w, g, r, dat, e);
            tests_run++; if (obs(s) !== {ery, ebv, erv, est, ecnt}) begin tests_failed++; $display("FAIL rand%0d_obs cyc %0d: got %b want %b", s, cyc, obs(s), {ery, ebv, erv, est, ecnt}); end
            tests_run++; if ({merr[s], breq[s]} !== {v && c, req[s]}) begin tests_failed++; $display("FAIL rand%0d_passthru cyc %0d: got %h want %h", s, cyc, {merr[s], breq[s]}, {v && c, req[s]}); end
            if (erv) begin
                tests_run++; if (cr[s].bus_resp !== ersp) begin tests_failed++; $display("FAIL rand%0d_resp cyc %0d: got %h want %h", s, cyc, cr[s].bus_resp, ersp); end
            end
            if (erv) void'(mq.pop_front());
            if (v && ery) begin
                ne = '{err: c, wr: w && !ifs, has: 1'b0, rsp: '0};
                mq.push_back(ne);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b000, MPU_OK, 4'd2}) begin tests_failed++; $display("FAIL rstmid_pre: got %b want %b", obs(0), {3'b000, MPU_OK, 4'd2}); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (obs(0) !== {3'b000, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL rstmid_async: got %b want %b", obs(0), {3'b000, MPU_OK, 4'd0}); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b100, MPU_OK, 4'd0}) begin tests_failed++; $display("FAIL rstmid_push: got %b want %b", obs(0), {3'b100, MPU_OK, 4'd0}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++; if (obs(0) !== {3'b001, MPU_RE_FAULT, 4'd1}) begin tests_failed++; $display("FAIL rstmid_fault: got %b want %b", obs(0), {3'b001, MPU_RE_FAULT, 4'd1}); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            tv[i] = 1'b0; tc[i] = 1'b0; tg[i] = 1'b0; rv[i] = 1'b0;
            req[i] = '0; rsp[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_fault_read();
        test_ordering();
        test_full();
        test_bypass();
        test_stored();
        test_random(0, 300);
        test_random(1, 300);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
